// File: rtl/dds_timer.sv
// dds_timer: DDS-style local time base.
// A 32-bit phase accumulator adds a fractional rate every cycle; its carry
// supplies the extra fraction unit on top of INT_STEP for the 64-bit time
// counter. It also captures timestamps on request and pulses pps on each new
// second.
// Optional build macro DDS_TIMER_RATE_CLAMP_EN: clamp loaded rates to
// [RATE_MIN, RATE_MAX] and flag every clamped load on rate_clamped.
module dds_timer #(
  parameter int          INT_STEP  = 34,
  parameter logic [31:0] RATE_INIT = 32'h896f750b,
  parameter logic [31:0] RATE_MIN  = 32'h80000000,
  parameter logic [31:0] RATE_MAX  = 32'h93000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dds_rate,
  input  logic        dds_valid,
  input  logic [63:0] time_load,
  input  logic        time_load_valid,
  input  logic        cap_req,
  output logic [63:0] time_now,
  output logic [63:0] cap_time,
  output logic        cap_valid,
  output logic        pps,
  output logic        rate_clamped
);

`ifdef DDS_TIMER_RATE_CLAMP_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  logic [31:0] rate_reg;
  logic [31:0] acc_reg;
  logic [63:0] time_reg;
  logic [63:0] cap_time_reg;
  logic        cap_valid_reg;
  logic        pps_reg;
  logic        rate_clamped_reg;

  logic [32:0] acc_sum;
  logic [63:0] time_inc;
  logic [31:0] rate_next;
  logic        clamp_hit;

  // Accumulator sum with carry-out, and the incremented time that uses it
  always_comb begin
    acc_sum  = {1'b0, acc_reg} + {1'b0, rate_reg};
    time_inc = time_reg + 64'(INT_STEP) + {63'd0, acc_sum[32]};
  end

  // Rate value to load; clamping is only active in the clamp build
  always_comb begin
    rate_next = dds_rate;
    clamp_hit = 1'b0;
    if (CLAMP_EN) begin
      if (dds_rate < RATE_MIN) begin
        rate_next = RATE_MIN;
        clamp_hit = 1'b1;
      end else if (dds_rate > RATE_MAX) begin
        rate_next = RATE_MAX;
        clamp_hit = 1'b1;
      end
    end
  end

  // Rate register: new rate takes effect from the edge after dds_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_reg         <= RATE_INIT;
      rate_clamped_reg <= 1'b0;
    end else begin
      rate_clamped_reg <= dds_valid & clamp_hit;
      if (dds_valid) begin
        rate_reg <= rate_next;
      end
    end
  end

  // Time counter and accumulator: a load wins over the increment and never pulses pps
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg  <= 32'd0;
      time_reg <= 64'd0;
      pps_reg  <= 1'b0;
    end else if (time_load_valid) begin
      acc_reg  <= 32'd0;
      time_reg <= time_load;
      pps_reg  <= 1'b0;
    end else begin
      acc_reg  <= acc_sum[31:0];
      time_reg <= time_inc;
      pps_reg  <= (time_inc[63:32] != time_reg[63:32]);
    end
  end

  // Timestamp capture of the pre-edge time; one strobe per request
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_time_reg  <= 64'd0;
      cap_valid_reg <= 1'b0;
    end else begin
      cap_valid_reg <= cap_req;
      if (cap_req) begin
        cap_time_reg <= time_reg;
      end
    end
  end

  assign time_now     = time_reg;
  assign cap_time     = cap_time_reg;
  assign cap_valid    = cap_valid_reg;
  assign pps          = pps_reg;
  assign rate_clamped = rate_clamped_reg;

endmodule

// File: doc/dds_timer.md
DDS_TIMER -- requirements
Module: dds_timer

Interface
REQ-001 Parameter INT_STEP, default 34: integer fraction-units added to the time counter every cycle.
REQ-002 Parameter RATE_INIT, default 32'h896f750b: reset value of the rate register.
REQ-003 Parameter RATE_MIN, default 32'h80000000: lower clamp bound (clamp build only).
REQ-004 Parameter RATE_MAX, default 32'h93000000: upper clamp bound (clamp build only).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 dds_rate  in  32  new fractional increment from the correction stage.
REQ-008 dds_valid  in  1  one-cycle strobe qualifying dds_rate.
REQ-009 time_load  in  64  absolute time; [63:32] seconds, [31:0] fraction.
REQ-010 time_load_valid  in  1  one-cycle strobe that overwrites the time counter.
REQ-011 cap_req  in  1  one-cycle strobe at sync-packet arrival requesting a timestamp.
REQ-012 time_now  out  64  free-running local time.
REQ-013 cap_time  out  64  captured timestamp; feeds Time_sync of the correction stage.
REQ-014 cap_valid  out  1  one-cycle strobe qualifying cap_time; feeds sync_valid.
REQ-015 pps  out  1  one-cycle pulse when the seconds field advances.
REQ-016 rate_clamped  out  1  one-cycle pulse when a loaded rate was clamped.

Function
REQ-017 The block SHALL hold a 32-bit rate register, a 32-bit phase accumulator and a 64-bit time counter.
REQ-018 On every non-load edge: acc <= acc + rate_reg (mod 2^32); time <= time + INT_STEP + carry, where carry is the carry-out of that sum.
REQ-019 Each edge SHALL use the rate_reg value held before that edge; on an edge with dds_valid=1, rate_reg <= dds_rate, which takes effect from the next edge.
REQ-020 On an edge with time_load_valid=1: time <= time_load and acc <= 0, and no increment is applied on that edge.
REQ-021 time_load_valid SHALL take priority over accumulation; dds_valid on the same edge SHALL still update rate_reg.
REQ-022 time_now SHALL equal the time counter register, with zero combinational path.
REQ-023 On an edge with cap_req=1: cap_time <= the time register value before that edge, and cap_valid <= 1 for exactly one cycle.
REQ-024 cap_req coincident with time_load_valid SHALL capture the pre-load time.
REQ-025 Back-to-back cap_req SHALL produce one cap_valid per request, with no loss.
REQ-026 On an increment edge that changes time[63:32]: pps <= 1 for one cycle, coincident with the first cycle time_now shows the new seconds.
REQ-027 A load edge SHALL never assert pps.
REQ-028 64-bit wrap from all-ones to zero SHALL be modular and SHALL assert pps.
REQ-029 The time counter SHALL never stall; dds_valid and cap_req need no ready/handshake.

Reset
REQ-030 While reset=1: rate_reg=RATE_INIT, acc=0, time=0, cap_time=0, cap_valid=0, pps=0, rate_clamped=0.
REQ-031 Reset SHALL override load, rate update and capture on the same edge.
REQ-032 Reset mid-operation SHALL drop any pending capture strobe.
REQ-033 The first increment SHALL occur on the first edge with reset=0.

Configuration
REQ-034 Macro DDS_TIMER_RATE_CLAMP_EN defined: dds_rate below RATE_MIN loads RATE_MIN, above RATE_MAX loads RATE_MAX, and rate_clamped pulses for one cycle after that load edge.
REQ-035 Macro undefined: dds_rate loads unchanged, and rate_clamped is tied 0.

Verification
REQ-036 Reset release with dds_rate=0x80000000 loaded, INT_STEP=34 -> time_now 34 then 69 then 103 then 138 on successive edges.
REQ-037 time_load=0x00000000_FFFFFFF0 then free-run -> next edge time_now=0x00000001_00000012, pps high for exactly that cycle.
REQ-038 cap_req with time_load_valid on the same edge, time_now=T -> cap_valid one cycle later, cap_time=T.
REQ-039 cap_req on three consecutive edges -> three cap_valid cycles carrying three consecutive time values.
REQ-040 Clamp build, dds_rate=0x10000000 -> rate_reg=0x80000000, rate_clamped one pulse; non-clamp build -> rate_reg=0x10000000, rate_clamped stays 0.
REQ-041 time_load=all-ones -> next edge time_now=INT_STEP-1+carry (modular), with pps asserted.
